rx_pkt_decoder: RTL and testbench
=================================

# rx_pkt_decoder

- **Role:** parametrised receive-path packet decoder for the USB host.
- **Position:** sits between the bit unstuffer and the receive CRC checker / protocol FSM.
- **Function:**
  - Captures the 8-bit PID and validates it.
  - Classifies the packet as token, data or handshake.
  - Forwards only the payload bits to the CRC checker, with start/end strobes.
  - Enforces per-kind payload length rules.
  - Holds error flags until the protocol FSM acknowledges them.

## Interface
Parameters:
- MAX_BITS, 8200 — maximum payload bits after the PID (data payload plus CRC16).
- LEN_W, $clog2(MAX_BITS+2) — width of the payload bit counter.
- ALLOW_SPECIAL, 0 — 1 accepts PID[1:0]=00 as kind SPECIAL; 0 flags it as PID error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Synchronous, active-low.
- abort  in  1  return to IDLE next cycle and clear all flags; has priority over every other input.
- start_decode  in  1  pulse, coincident with the first PID bit (s_valid=1 in the same cycle).
- s_in  in  1  unstuffed serial bit, LSB first.
- s_valid  in  1  s_in carries a real bit this cycle (low on stuffed-bit slots).
- end_decode  in  1  EOP pulse; no bit is valid in this cycle.
- err_ack  in  1  protocol FSM acknowledges an error; flags clear and the block leaves ERROR.
- s_out  out  1  equals s_in (combinational).
- s_out_valid  out  1  s_valid && state==PAYLOAD.
- start_rc_crc  out  1  pulse with the first forwarded payload bit.
- end_rc_crc  out  1  pulse with end_decode in PAYLOAD, only if at least 1 bit was forwarded.
- pid  out  4  captured PID.
- pid_kind  out  2  NONE=00, TOKEN=01, HSHAKE=10, DATA=11. SPECIAL uses the NONE code; only legal when ALLOW_SPECIAL=1.
- pkt_len  out  LEN_W  payload bits counted (PID excluded).
- pkt_done  out  1  pulse when a packet completes cleanly.
- PID_error  out  1  level; held until err_ack or abort.
- len_error  out  1  level; held until err_ack or abort.
- busy  out  1  state != IDLE.

## Operation
States: IDLE, PID, PAYLOAD, CHECK, ERROR.

- **IDLE**
  - start_decode → PID; the bit in that cycle counts as PID bit 0.
  - end_decode is ignored.
- **PID**
  - Shift in s_valid bits until 8 have been captured.
  - On the 8th bit, the PID is valid iff bits[7:4] == ~bits[3:0] and the kind is legal.
  - Valid → PAYLOAD; latch pid and pid_kind.
  - Invalid → ERROR with PID_error=1.
  - end_decode before 8 bits → ERROR with PID_error=1.
- **PAYLOAD**
  - Each s_valid bit is forwarded and increments pkt_len. pkt_len saturates at MAX_BITS+1.
  - pkt_len > MAX_BITS → ERROR immediately with len_error=1.
  - end_decode → CHECK.
- **CHECK** (one cycle). Length rules:
  - TOKEN: exactly 16.
  - HSHAKE: 0.
  - DATA: ≥16 and a multiple of 8.
  - SPECIAL: no check.
  - Pass → pkt_done and go to IDLE. Fail → len_error=1 and go to ERROR.
- **ERROR**
  - Flags stay high.
  - err_ack → IDLE, with flags cleared in the same transition.
- **Other rules**
  - start_decode outside IDLE is ignored.
  - Handshake packets never raise start_rc_crc or end_rc_crc.

## Timing
- **Reset / abort values:** state IDLE, pid=0, pid_kind=NONE, pkt_len=0, and all strobes and flags 0.
- **pid / pid_kind:**
  - Valid from the cycle after the 8th PID bit.
  - Held until the next accepted start_decode.
  - Not updated when the PID is invalid.
- **Error timing:** PID_error rises the cycle after the 8th bit or after the early end_decode.
- **s_out:** zero latency.
- **start_rc_crc:** asserted in the same cycle as the first s_out_valid.
- **end_rc_crc:** asserted in the end_decode cycle.
- **pkt_done:** asserted the cycle after end_decode.
- **len_error on length rules:** asserted the cycle after end_decode.
- **Simultaneous events:**
  - abort with anything: abort wins.
  - err_ack in a non-ERROR state: ignored.
  - err_ack together with start_decode in ERROR: go to IDLE; start_decode is dropped.
- **pkt_len:** cleared on an accepted start_decode; otherwise held until then.

## Structure
- **Package usb_rx_pkg:**
  - pid_kind_t enum.
  - PID constants: ACK=4'h2, DATA0=4'h3, OUT=4'h1, IN=4'h9.
  - rx_state_t enum.
- **Sub-module pid_shift_check:**
  - 8-bit shift register, 3-bit counter and complement/kind check.
  - Outputs pid_done, pid_ok, pid, kind.
- **rx_pkt_decoder top:** FSM, length counter and CRC strobe logic.

## Test plan
- **ACK:** byte 8'hD2 then end_decode → pid=2, kind=HSHAKE, pkt_len=0; pkt_done pulses; no CRC strobes.
- **OUT token:** 8'hE1 plus 16 bits, with a stuffed slot (s_valid=0) mid-payload → exactly 16 s_out_valid; start_rc_crc and end_rc_crc once each; pkt_done.
- **Bad PID:** 8'hD3 → PID_error rises the cycle after bit 8 and holds 5 cycles. err_ack → IDLE and flag cleared.
- **DATA0 too long:** MAX_BITS=64, DATA0 8'hC3 plus 65 bits → len_error in the cycle after bit 65. DATA0 plus 20 bits then end_decode → len_error (not a multiple of 8).
- **Early EOP:** end_decode after 5 PID bits → PID_error.
- **Abort:** abort during PAYLOAD → next cycle state IDLE, all flags and strobes 0, no pkt_done. Repeat the same test with rst_n low mid-payload → same result.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive-path packet decoder.
//   pid_kind_t  : packet class reported on pid_kind (SPECIAL shares the NONE code)
//   rx_state_t  : decoder FSM states
//   PID_*       : frequently used 4-bit PID values
//   len_rule_ok : payload length rule per packet class
package usb_rx_pkg;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'b00,
    KIND_TOKEN  = 2'b01,
    KIND_HSHAKE = 2'b10,
    KIND_DATA   = 2'b11
  } pid_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PID     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHECK   = 3'd3,
    ST_ERROR   = 3'd4
  } rx_state_t;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_IN    = 4'h9;

  // Token payload is ADDR+ENDP+CRC5 (16 bits); handshakes carry nothing;
  // data payloads are whole bytes and at least the CRC16. SPECIAL is unchecked.
  function automatic logic len_rule_ok(input pid_kind_t kind, input int unsigned len);
    logic ok;
    case (kind)
      KIND_TOKEN:  ok = (len == 32'd16);
      KIND_HSHAKE: ok = (len == 32'd0);
      KIND_DATA:   ok = (len >= 32'd16) && (len[2:0] == 3'd0);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rx_pkt_decoder_if.sv
// Bus between the bit unstuffer / protocol FSM / CRC checker and the decoder.
//   master : drives abort, start_decode, s_in, s_valid, end_decode, err_ack
//   slave  : the decoder; drives the forwarded bit stream, CRC strobes,
//            captured PID/kind, payload length, completion and error flags
interface rx_pkt_decoder_if #(
  parameter int LEN_W = 14
);
  import usb_rx_pkg::*;

  logic             abort;
  logic             start_decode;
  logic             s_in;
  logic             s_valid;
  logic             end_decode;
  logic             err_ack;
  logic             s_out;
  logic             s_out_valid;
  logic             start_rc_crc;
  logic             end_rc_crc;
  logic [3:0]       pid;
  pid_kind_t        pid_kind;
  logic [LEN_W-1:0] pkt_len;
  logic             pkt_done;
  logic             PID_error;
  logic             len_error;
  logic             busy;

  modport master (
    output abort, start_decode, s_in, s_valid, end_decode, err_ack,
    input  s_out, s_out_valid, start_rc_crc, end_rc_crc, pid, pid_kind,
           pkt_len, pkt_done, PID_error, len_error, busy
  );

  modport slave (
    input  abort, start_decode, s_in, s_valid, end_decode, err_ack,
    output s_out, s_out_valid, start_rc_crc, end_rc_crc, pid, pid_kind,
           pkt_len, pkt_done, PID_error, len_error, busy
  );

endinterface

// File: rtl/rx_pkt_decoder_pid_shift_check.sv
// PID capture: 8-bit LSB-first shift register with a 3-bit bit counter and
// the complement / kind legality check, evaluated on the 8th bit.
//   clr_i      : clear shifter and counter (abort)
//   start_i    : load bit_i as PID bit 0
//   shift_i    : shift in bit_i as the next PID bit
//   pid_done_o : this cycle carries PID bit 7
//   pid_ok_o   : complete byte is a legal PID (valid only with pid_done_o)
//   pid_o      : low nibble of the complete byte
//   kind_o     : packet class from PID[1:0]
module pid_shift_check
  import usb_rx_pkg::*;
#(
  parameter bit ALLOW_SPECIAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       start_i,
  input  logic       shift_i,
  input  logic       bit_i,
  output logic       pid_done_o,
  output logic       pid_ok_o,
  output logic [3:0] pid_o,
  output pid_kind_t  kind_o
);

  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] byte_s;

  // Byte as it will look once bit_i is shifted in; complete when cnt_q==7.
  always_comb begin
    byte_s     = {bit_i, sr_q[7:1]};
    pid_done_o = shift_i && (cnt_q == 3'd7);
    pid_o      = byte_s[3:0];
    kind_o     = pid_kind_t'(byte_s[1:0]);
    pid_ok_o   = (byte_s[7:4] == ~byte_s[3:0]) &&
                 (ALLOW_SPECIAL || (byte_s[1:0] != 2'b00));
  end

  // Shifter / counter next state; the start bit is PID bit 0.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      sr_d  = 8'h00;
      cnt_d = 3'd0;
    end else if (start_i) begin
      sr_d  = byte_s;
      cnt_d = 3'd1;
    end else if (shift_i) begin
      sr_d  = byte_s;
      cnt_d = cnt_q + 3'd1;
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end
  end

  // Shifter / counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q  <= 8'h00;
      cnt_q <= 3'd0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rx_pkt_decoder.sv
// Receive-path packet decoder: captures and validates the PID, classifies the
// packet, forwards payload bits to the CRC checker with start/end strobes,
// checks the per-kind payload length and holds error flags until err_ack.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : rx_pkt_decoder_if slave (serial input, control pulses,
//                forwarded stream, CRC strobes, pid/kind/len, flags, busy)
module rx_pkt_decoder
  import usb_rx_pkg::*;
#(
  parameter int MAX_BITS      = 8200,
  parameter int LEN_W         = $clog2(MAX_BITS + 2),
  parameter bit ALLOW_SPECIAL = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  rx_pkt_decoder_if.slave bus
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_BITS);
  localparam logic [LEN_W-1:0] LEN_SAT  = LEN_W'(MAX_BITS + 1);

  rx_state_t        state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  pid_kind_t        kind_q, kind_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             pid_err_q, pid_err_d;
  logic             len_err_q, len_err_d;
  logic             done_q, done_d;

  logic             pid_clr_s, pid_start_s, pid_shift_s;
  logic             pid_done_s, pid_ok_s;
  logic [3:0]       pid_val_s;
  pid_kind_t        pid_kind_s;
  logic             crc_en_s;

  pid_shift_check #(
    .ALLOW_SPECIAL(ALLOW_SPECIAL)
  ) u_pid (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (pid_clr_s),
    .start_i    (pid_start_s),
    .shift_i    (pid_shift_s),
    .bit_i      (bus.s_in),
    .pid_done_o (pid_done_s),
    .pid_ok_o   (pid_ok_s),
    .pid_o      (pid_val_s),
    .kind_o     (pid_kind_s)
  );

  // FSM next state, captured fields, length counter and flags; abort first.
  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    kind_d      = kind_q;
    len_d       = len_q;
    pid_err_d   = pid_err_q;
    len_err_d   = len_err_q;
    done_d      = 1'b0;
    pid_clr_s   = 1'b0;
    pid_start_s = 1'b0;
    pid_shift_s = 1'b0;
    if (bus.abort) begin
      state_d   = ST_IDLE;
      pid_d     = 4'h0;
      kind_d    = KIND_NONE;
      len_d     = LEN_ZERO;
      pid_err_d = 1'b0;
      len_err_d = 1'b0;
      pid_clr_s = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start_decode) begin
            state_d     = ST_PID;
            len_d       = LEN_ZERO;
            pid_start_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PID: begin
          pid_shift_s = bus.s_valid && !bus.end_decode;
          if (bus.end_decode) begin
            state_d   = ST_ERROR;
            pid_err_d = 1'b1;
          end else if (pid_done_s && pid_ok_s) begin
            state_d = ST_PAYLOAD;
            pid_d   = pid_val_s;
            kind_d  = pid_kind_s;
          end else if (pid_done_s) begin
            state_d   = ST_ERROR;
            pid_err_d = 1'b1;
          end else begin
            state_d = ST_PID;
          end
        end
        ST_PAYLOAD: begin
          // The verdict is registered here so pkt_done / len_error show in CHECK.
          if (bus.end_decode) begin
            state_d = ST_CHECK;
            if (len_rule_ok(kind_q, 32'(len_q))) begin
              done_d = 1'b1;
            end else begin
              len_err_d = 1'b1;
            end
          end else if (bus.s_valid) begin
            len_d = (len_q == LEN_SAT) ? len_q : (len_q + LEN_ONE);
            if (len_q >= LEN_MAX) begin
              state_d   = ST_ERROR;
              len_err_d = 1'b1;
            end else begin
              state_d = ST_PAYLOAD;
            end
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_CHECK: begin
          state_d = len_err_q ? ST_ERROR : ST_IDLE;
        end
        ST_ERROR: begin
          if (bus.err_ack) begin
            state_d   = ST_IDLE;
            pid_err_d = 1'b0;
            len_err_d = 1'b0;
          end else begin
            state_d = ST_ERROR;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Forwarded stream and CRC strobes; handshakes never reach the CRC checker.
  always_comb begin
    crc_en_s         = (kind_q != KIND_HSHAKE) && !bus.abort;
    bus.s_out        = bus.s_in;
    bus.s_out_valid  = bus.s_valid && (state_q == ST_PAYLOAD);
    bus.start_rc_crc = bus.s_out_valid && (len_q == LEN_ZERO) && crc_en_s;
    bus.end_rc_crc   = (state_q == ST_PAYLOAD) && bus.end_decode &&
                       (len_q != LEN_ZERO) && crc_en_s;
    bus.pid          = pid_q;
    bus.pid_kind     = kind_q;
    bus.pkt_len      = len_q;
    bus.pkt_done     = done_q;
    bus.PID_error    = pid_err_q;
    bus.len_error    = len_err_q;
    bus.busy         = (state_q != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pid_q     <= 4'h0;
      kind_q    <= KIND_NONE;
      len_q     <= LEN_ZERO;
      pid_err_q <= 1'b0;
      len_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pid_q     <= pid_d;
      kind_q    <= kind_d;
      len_q     <= len_d;
      pid_err_q <= pid_err_d;
      len_err_q <= len_err_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_rx_pkt_decoder.sv
// Directed bench for rx_pkt_decoder (MAX_BITS=64, ALLOW_SPECIAL=0).
// A packet-level model turns each packet description into the per-cycle
// output trace the decoder must show; one negedge process compares it.
module tb_rx_pkt_decoder;
  import usb_rx_pkg::*;

  localparam int MAXB = 64;
  localparam int LW   = $clog2(MAXB + 2);
  localparam bit L    = 1'b0;
  localparam bit H    = 1'b1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  rx_pkt_decoder_if #(.LEN_W(LW)) bus ();

  rx_pkt_decoder #(
    .MAX_BITS(MAXB), .LEN_W(LW), .ALLOW_SPECIAL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       busy, sov, src, erc, done, pide, lene, sout;
    logic [3:0] pid;
    logic [1:0] kind;
    int         len;
  } exp_t;

  exp_t expq[$];

  // Values the decoder must present in the cycle being driven next.
  logic       m_busy = 1'b0, m_pide = 1'b0, m_lene = 1'b0;
  logic [3:0] m_pid  = 4'h0;
  logic [1:0] m_kind = 2'b00;
  int         m_len  = 0;
  int         n_sov = 0, n_src = 0, n_erc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model trace, plus strobe tallies.
  always @(negedge clk) begin
    exp_t e;
    if (bus.s_out_valid === 1'b1) n_sov++;
    if (bus.start_rc_crc === 1'b1) n_src++;
    if (bus.end_rc_crc === 1'b1) n_erc++;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("busy", bus.busy, e.busy);
      chk("s_out", bus.s_out, e.sout);
      chk("s_out_valid", bus.s_out_valid, e.sov);
      chk("start_rc_crc", bus.start_rc_crc, e.src);
      chk("end_rc_crc", bus.end_rc_crc, e.erc);
      chk("pkt_done", bus.pkt_done, e.done);
      chk("PID_error", bus.PID_error, e.pide);
      chk("len_error", bus.len_error, e.lene);
      chk("pid", bus.pid, e.pid);
      chk("pid_kind", bus.pid_kind, e.kind);
      chk("pkt_len", bus.pkt_len, e.len);
    end
  end

  task automatic cyc(input bit sd, input bit si, input bit sv, input bit ed,
                     input bit ea, input bit ab, input bit rs,
                     input bit e_sov, input bit e_src, input bit e_erc, input bit e_done);
    exp_t e;
    @(posedge clk);
    #1;
    bus.start_decode = sd;
    bus.s_in         = si;
    bus.s_valid      = sv;
    bus.end_decode   = ed;
    bus.err_ack      = ea;
    bus.abort        = ab;
    rst_n            = !rs;
    e.busy = m_busy; e.sov = e_sov; e.src = e_src; e.erc = e_erc; e.done = e_done;
    e.pide = m_pide; e.lene = m_lene; e.sout = si;
    e.pid  = m_pid;  e.kind = m_kind; e.len = m_len;
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(L, L, L, L, L, L, L, L, L, L, L);
  endtask

  task automatic ack(input bit sd);
    cyc(sd, L, sd, L, H, L, L, L, L, L, L);
    if (m_pide || m_lene) begin
      m_pide = 1'b0; m_lene = 1'b0; m_busy = 1'b0;
    end
  endtask

  task automatic kill(input bit use_reset);
    cyc(L, L, L, L, L, !use_reset, use_reset, L, L, L, L);
    m_busy = 1'b0; m_pide = 1'b0; m_lene = 1'b0;
    m_pid = 4'h0; m_kind = 2'b00; m_len = 0;
  endtask

  // One packet: npid PID bits (early EOP if < 8), npay payload bits with an
  // optional stuffed slot before bit stuff_at, then EOP if eop is set.
  task automatic pkt(input logic [7:0] b, input int npid, input int npay,
                     input int stuff_at, input bit eop);
    bit ok, hs, rule, si;
    logic [1:0] k;
    cyc(H, b[0], H, L, L, L, L, L, L, L, L);
    m_busy = 1'b1;
    m_len  = 0;
    for (int i = 1; i < npid; i++) cyc(L, b[i], H, L, L, L, L, L, L, L, L);
    if (npid < 8) begin
      cyc(L, L, L, H, L, L, L, L, L, L, L);
      m_pide = 1'b1;
      return;
    end
    k  = b[1:0];
    ok = (b[7:4] == ~b[3:0]) && (k != 2'b00);
    if (!ok) begin
      m_pide = 1'b1;
      return;
    end
    m_pid  = b[3:0];
    m_kind = k;
    hs     = (k == 2'b10);
    for (int i = 0; i < npay; i++) begin
      if (i == stuff_at) cyc(L, H, L, L, L, L, L, L, L, L, L);
      si = ((i % 3) == 0);
      cyc(L, si, H, L, L, L, L, H, (i == 0) && !hs, L, L);
      m_len = i + 1;
      if (m_len > MAXB) begin
        m_lene = 1'b1;
        return;
      end
    end
    if (!eop) return;
    cyc(L, L, L, H, L, L, L, L, L, (npay > 0) && !hs, L);
    case (k)
      2'b01:   rule = (npay == 16);
      2'b10:   rule = (npay == 0);
      2'b11:   rule = (npay >= 16) && ((npay % 8) == 0);
      default: rule = 1'b1;
    endcase
    m_lene = !rule;
    cyc(L, L, L, L, L, L, L, L, L, L, rule);
    if (rule) m_busy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.abort = 1'b0; bus.start_decode = 1'b0; bus.s_in = 1'b0;
    bus.s_valid = 1'b0; bus.end_decode = 1'b0; bus.err_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", bus.busy, 32'd0);
    chk("rst pid", bus.pid, 32'd0);
    chk("rst pid_kind", bus.pid_kind, 32'd0);
    chk("rst pkt_len", bus.pkt_len, 32'd0);
    chk("rst flags", {bus.PID_error, bus.len_error, bus.pkt_done}, 32'd0);
    idle(2);

    // ACK handshake
    n_sov = 0; n_src = 0; n_erc = 0;
    pkt(8'hD2, 8, 0, -1, H);
    #2;
    chk("ack pid", bus.pid, 32'h2);
    chk("ack kind", bus.pid_kind, 32'd2);
    chk("ack len", bus.pkt_len, 32'd0);
    chk("ack done", bus.pkt_done, 32'd1);
    chk("ack crc strobes", n_src + n_erc, 32'd0);
    idle(1);

    // OUT token with a stuffed slot mid-payload
    n_sov = 0; n_src = 0; n_erc = 0;
    pkt(8'hE1, 8, 16, 7, H);
    #2;
    chk("out done", bus.pkt_done, 32'd1);
    chk("out len", bus.pkt_len, 32'd16);
    chk("out sov count", n_sov, 32'd16);
    chk("out start_rc count", n_src, 32'd1);
    chk("out end_rc count", n_erc, 32'd1);
    idle(1);
    ack(L);
    idle(1);

    // Bad PID: flag held, pid keeps the previous value, cleared by err_ack
    pkt(8'hD3, 8, 0, -1, H);
    idle(1);
    #2;
    chk("bad pid flag", bus.PID_error, 32'd1);
    chk("bad pid held pid", bus.pid, 32'h1);
    idle(4);
    ack(L);
    idle(1);
    #2;
    chk("bad pid cleared", bus.PID_error, 32'd0);
    chk("bad pid idle", bus.busy, 32'd0);

    // DATA0 overflow; err_ack with start_decode drops the start
    pkt(8'hC3, 8, 65, 30, H);
    idle(1);
    #2;
    chk("ovf len_error", bus.len_error, 32'd1);
    chk("ovf pkt_len", bus.pkt_len, 32'd65);
    idle(2);
    ack(H);
    idle(2);

    // DATA0 20 bits (not whole bytes) then 24 bits (fine)
    pkt(8'hC3, 8, 20, -1, H);
    #2;
    chk("d20 len_error", bus.len_error, 32'd1);
    chk("d20 pkt_len", bus.pkt_len, 32'd20);
    idle(1);
    ack(L);
    pkt(8'hC3, 8, 24, 3, H);
    #2;
    chk("d24 done", bus.pkt_done, 32'd1);
    idle(1);

    // Short token, IN token, special PID rejected, early EOP
    pkt(8'hE1, 8, 15, -1, H);
    idle(1);
    ack(L);
    pkt(8'h69, 8, 16, 0, H);
    #2;
    chk("in pid", bus.pid, 32'h9);
    idle(1);
    pkt(8'hF0, 8, 0, -1, H);
    idle(2);
    ack(L);
    pkt(8'hC3, 5, 0, -1, H);
    idle(1);
    #2;
    chk("early eop flag", bus.PID_error, 32'd1);
    ack(L);
    idle(1);

    // Abort, then synchronous reset, in the middle of a payload
    for (int r = 0; r < 2; r++) begin
      pkt(8'hE1, 8, 6, -1, L);
      kill(r == 1);
      idle(1);
      #2;
      chk("kill busy", bus.busy, 32'd0);
      chk("kill pid", bus.pid, 32'd0);
      chk("kill len", bus.pkt_len, 32'd0);
      chk("kill flags", {bus.PID_error, bus.len_error, bus.pkt_done}, 32'd0);
      idle(3);
    end

    @(negedge clk);
    #1;
    chk("trace drained", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
